// File: rtl/wb_stage_pkg.sv
// Shared MEM/WB pipeline definitions: load-type encodings, the zero register and the MEM/WB bundle.
package wb_stage_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_t;

  localparam logic [PIPE_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic [2:0]             load_type;
    logic [PIPE_ADDR_W-1:0] wr_addr;
    logic [PIPE_DATA_W-1:0] alu_result;
    logic [PIPE_DATA_W-1:0] load_data;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Big-endian byte/halfword select with sign/zero extension, plus the alignment check for the access size.
module load_formatter
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ld,
  input  logic [1:0]        off,
  input  logic [2:0]        lt,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld[31:24];
    case (off)
      2'd0: byte_sel = ld[31:24];
      2'd1: byte_sel = ld[23:16];
      2'd2: byte_sel = ld[15:8];
      2'd3: byte_sel = ld[7:0];
      default: byte_sel = ld[31:24];
    endcase
    half_sel = off[1] ? ld[15:0] : ld[31:16];
  end

  // Unused encodings 101-111 fall through to the word path.
  always_comb begin
    data       = ld;
    misaligned = 1'b0;
    case (lt)
      LT_LH: begin
        data       = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      LT_LHU: begin
        data       = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned = off[0];
      end
      LT_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
      default: begin
        data       = ld;
        misaligned = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load formatting, RF write port, EX bypass source and retired counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [2:0]        mem_load_type,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              wb_hold,
  input  logic              wb_flush,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              v, rw, m2r, done;
  logic [2:0]        lt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] alu, ld;

  logic [DATA_W-1:0] fmt_data;
  logic              fmt_misaligned;
  logic              misaligned;
  logic              we;
  logic [DATA_W-1:0] res;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v    <= 1'b0;
      done <= 1'b0;
      rw   <= 1'b0;
      m2r  <= 1'b0;
      lt   <= '0;
      addr <= '0;
      alu  <= '0;
      ld   <= '0;
    end else if (wb_flush) begin
      v    <= 1'b0;
      done <= 1'b0;
    end else if (wb_hold) begin
      // done marks the write/retire as already issued so held edges cannot repeat it
      if (v) done <= 1'b1;
    end else begin
      v    <= mem_valid;
      done <= 1'b0;
      rw   <= mem_reg_write;
      m2r  <= mem_mem_to_reg;
      lt   <= mem_load_type;
      addr <= mem_wr_addr;
      alu  <= mem_alu_result;
      ld   <= mem_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      retired_cnt <= '0;
    else if (v && !done)
      retired_cnt <= retired_cnt + CNT_W'(1);
  end

  load_formatter #(.DATA_W(DATA_W)) u_fmt (
    .ld         (ld),
    .off        (alu[1:0]),
    .lt         (lt),
    .data       (fmt_data),
    .misaligned (fmt_misaligned)
  );

  // Alignment only matters for loads; ALU results carry arbitrary low bits.
  assign misaligned   = m2r & fmt_misaligned;
  assign res          = m2r ? fmt_data : alu;
  assign we           = v & rw & (addr != ADDR_W'(REG_ZERO)) & ~misaligned;
  assign RegWrite     = we & ~done;
  assign wr_addr      = addr;
  assign wr_data      = res;
  assign fwd_valid    = we;
  assign fwd_addr     = addr;
  assign fwd_data     = res;
  assign misalign_err = v & misaligned & ~done;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage MIPS pipeline. Latches the MEM/WB bundle, formats load data (sign/zero extension, big-endian byte/halfword select) and drives the register-file write port (`RegWrite`, `wr_addr`, `wr_data`). It also exports the same result as a bypass source for the EX-stage forwarding mux, and keeps a retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 32: datapath width.
- `ADDR_W`, 5: register-address width.
- `CNT_W`, 32: retired-counter width.

Ports:
- `clk`  in  1: clock. All state updates on the posedge.
- `rst`  in  1: reset. One clock; reset is synchronous and active-low (`rst`=0 at a posedge resets).
- `mem_valid`  in  1: MEM stage presents an instruction this cycle.
- `mem_reg_write`  in  1: instruction writes a GPR.
- `mem_mem_to_reg`  in  1: 1 selects load data, 0 selects ALU result.
- `mem_load_type`  in  3: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101–111 are treated as LW.
- `mem_wr_addr`  in  ADDR_W: destination register.
- `mem_alu_result`  in  DATA_W: ALU result, or effective address for loads.
- `mem_load_data`  in  DATA_W: raw aligned word from data memory.
- `wb_hold`  in  1: freeze the WB register (global stall).
- `wb_flush`  in  1: kill the WB contents.
- `RegWrite`  out  1: RF write enable.
- `wr_addr`  out  ADDR_W: RF write address.
- `wr_data`  out  DATA_W: RF write data.
- `fwd_valid`  out  1: bypass data valid.
- `fwd_addr`  out  ADDR_W: bypass destination.
- `fwd_data`  out  DATA_W: bypass value; equals `wr_data`.
- `misalign_err`  out  1: one-cycle pulse on a misaligned load.
- `retired_cnt`  out  CNT_W: instructions retired.

## Operation
- **WB register contents:** `v`, `rw`, `m2r`, `lt`, `addr`, `alu`, `ld`, plus a `done` flag.
- **Load** (at a posedge with `rst`=1, `wb_hold`=0, `wb_flush`=0):
  - `v`←`mem_valid`; all fields take their `mem_*` values.
  - `done`←0.
- **Hold** (`wb_hold`=1): all fields keep their values. `done`←1 if `v`.
- **Flush** (`wb_flush`=1): `v`←0 and `done`←0. Flush has priority over hold and load.
- **Load formatting** (big-endian, `off`=`alu[1:0]`):
  - LW: the whole word.
  - LH/LHU: `off[1]`=0 selects `ld[31:16]`, 1 selects `ld[15:0]`; sign- or zero-extend.
  - LB/LBU: byte `off` selects `ld[31-8*off -: 8]`; sign- or zero-extend.
- **Misalignment:** LW with `off`≠0, or LH/LHU with `off[0]`=1.
  - Suppresses the write.
  - Raises `misalign_err` for that instruction's first WB cycle only.
- **Result:** `res` = `m2r` ? formatted load : `alu`.
- **Write/forward enables:**
  - `we` = `v` & `rw` & (`addr`≠0) & !misaligned.
  - `RegWrite` = `we` & !`done`.
  - `fwd_valid` = `we`. `fwd_valid` stays high while held, because the value is still architecturally pending to readers that stalled with it.
- **Retired counter:** `retired_cnt` increments once per instruction, in the cycle with `v` & !`done` (misaligned and non-writing instructions included). Wraps modulo 2^CNT_W.
- **Reset values:** `v`=0, `done`=0, `retired_cnt`=0. Therefore `RegWrite`=0, `fwd_valid`=0, `misalign_err`=0.
  - `wr_addr`, `wr_data`, `fwd_addr`, `fwd_data` are 0 after reset because all data fields are cleared.

## Timing
- **Latency:** bundle accepted at edge N → `RegWrite`/`wr_*` valid during cycle N→N+1 → RF updates at edge N+1.
- All outputs are combinational from WB register state only. There is no path from `mem_*` inputs to outputs.
- **Hold:**
  - `RegWrite` is high for at most one cycle per instruction.
  - Edges while held never produce a second write.
  - The counter does not re-increment.
- **Back-to-back instructions:** one write per cycle. No bubbles are inserted.
- **Hold and flush on the same edge:** flush wins.
- **Reset mid-hold:** everything clears and no write is issued.
- **`wr_addr`=0:** `RegWrite` stays 0 and `fwd_valid` stays 0. The counter still increments.

## Structure
- **Shared pipeline package:**
  - `load_type_t` encodings (LW/LH/LHU/LB/LBU).
  - `REG_ZERO`=0.
  - The MEM/WB bundle struct (`mem_wb_t`), also used by `mem_stage`.
- **Sub-module:** `load_formatter`, purely combinational. Inputs `ld`, `off`, `lt`; outputs the formatted data and the `misaligned` flag. It is reused by the testbench's reference model.

## Test plan
- **ALU write:** `mem_valid`=1, `rw`=1, `m2r`=0, addr=5, alu=0x12345678 → next cycle `RegWrite`=1, `wr_addr`=5, `wr_data`=0x12345678; `retired_cnt` 0→1.
- **Load formatting:** ld=0x80FF7F01.
  - LB off=0 → 0xFFFFFF80.
  - LBU off=1 → 0x000000FF.
  - LH off=2 → 0x00007F01.
  - LHU off=0 → 0x000080FF.
  - LW off=0 → 0x80FF7F01.
- **Misaligned:**
  - LW with alu=0x1002 → `RegWrite`=0 and a one-cycle `misalign_err`; counter increments.
  - LH with off=1 → same response.
- **Hold:** instruction addr=7 enters, then `wb_hold`=1 for 3 cycles.
  - `RegWrite` is high only in the first cycle.
  - `fwd_valid`=1 for all 4 cycles.
  - Counter +1 total.
- **Register 0:** write to register 0 → `RegWrite`=0, `fwd_valid`=0, counter +1.
- **Flush and reset:**
  - `wb_flush` concurrent with `wb_hold` → `v`=0 next cycle, no write.
  - `rst`=0 for one edge mid-stream → all outputs 0 and `retired_cnt`=0.
  - Counter preset near 2^CNT_W−1 (via CNT_W=4 build) wraps 15→0.
